// File: rtl/coord_walk_checker.sv
// Receive-side checker for the raster x/y coordinate walk. It locks on (0,0),
// predicts each next pair and counts mismatches and completed frames.
// Optional build macro: COORD_CHK_RESYNC_EN (resync on mismatch instead of rehunting).
module coord_walk_checker #(
  parameter int W     = 4,
  parameter int X_MAX = 3,
  parameter int Y_MAX = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  output logic             locked,
  output logic [W-1:0]     exp_x,
  output logic [W-1:0]     exp_y,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam logic [W-1:0]     XM      = W'(X_MAX);
  localparam logic [W-1:0]     YM      = W'(Y_MAX);
  localparam logic [W-1:0]     ONE_W   = W'(1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     exp_x_reg, exp_x_next;
  logic [W-1:0]     exp_y_reg, exp_y_next;
  logic             err_pulse_reg, err_pulse_next;
  logic             frame_done_reg, frame_done_next;
  logic [CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [CNT_W-1:0] frame_cnt_reg, frame_cnt_next;

  logic [W-1:0] succ_x, succ_y;
  logic         in_zero, in_match, in_last;
`ifdef COORD_CHK_RESYNC_EN
  logic         in_range;
`endif

  // Raster successor of the received pair; on a match this equals the successor of exp.
  always_comb begin
    succ_x = '0;
    succ_y = '0;
    if (in_x < XM) begin
      succ_x = in_x + ONE_W;
      succ_y = in_y;
    end else if (in_y < YM) begin
      succ_x = '0;
      succ_y = in_y + ONE_W;
    end
  end

  assign in_zero  = (in_x == '0) && (in_y == '0);
  assign in_match = (in_x == exp_x_reg) && (in_y == exp_y_reg);
  assign in_last  = (in_x == XM) && (in_y == YM);
`ifdef COORD_CHK_RESYNC_EN
  assign in_range = (in_x <= XM) && (in_y <= YM);
`endif

  always_comb begin
    state_next      = state_reg;
    exp_x_next      = exp_x_reg;
    exp_y_next      = exp_y_reg;
    err_pulse_next  = 1'b0;
    frame_done_next = 1'b0;
    err_cnt_next    = err_cnt_reg;
    frame_cnt_next  = frame_cnt_reg;
    if (in_valid) begin
      case (state_reg)
        HUNT: begin
          if (in_zero) begin
            state_next = TRACK;
            exp_x_next = succ_x;
            exp_y_next = succ_y;
          end
        end
        TRACK: begin
          if (in_match) begin
            exp_x_next = succ_x;
            exp_y_next = succ_y;
            if (in_last) begin
              frame_done_next = 1'b1;
              frame_cnt_next  = frame_cnt_reg + ONE_CNT;
            end
          end else begin
            err_pulse_next = 1'b1;
            if (err_cnt_reg != '1)
              err_cnt_next = err_cnt_reg + ONE_CNT;
`ifdef COORD_CHK_RESYNC_EN
            // Adopt the received pair as the new reference when it is a legal coordinate.
            if (in_range) begin
              exp_x_next = succ_x;
              exp_y_next = succ_y;
            end else begin
              state_next = HUNT;
              exp_x_next = '0;
              exp_y_next = '0;
            end
`else
            state_next = HUNT;
            exp_x_next = '0;
            exp_y_next = '0;
`endif
          end
        end
        default: begin
          state_next = HUNT;
          exp_x_next = '0;
          exp_y_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= HUNT;
      exp_x_reg      <= '0;
      exp_y_reg      <= '0;
      err_pulse_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      err_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      exp_x_reg      <= exp_x_next;
      exp_y_reg      <= exp_y_next;
      err_pulse_reg  <= err_pulse_next;
      frame_done_reg <= frame_done_next;
      err_cnt_reg    <= err_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
    end
  end

  assign locked     = (state_reg == TRACK);
  assign exp_x      = exp_x_reg;
  assign exp_y      = exp_y_reg;
  assign err_pulse  = err_pulse_reg;
  assign frame_done = frame_done_reg;
  assign err_cnt    = err_cnt_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_coord_walk_checker.sv
// Scoreboard bench for coord_walk_checker: a behavioural model queues the expected
// outputs for each driven cycle, and they are compared one cycle later.
module tb_coord_walk_checker;
  localparam int W = 4, XM = 3, YM = 3, CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_x, in_y;
  logic          locked, err_pulse, frame_done;
  logic [W-1:0]  exp_x, exp_y;
  logic [CW-1:0] err_cnt, frame_cnt;

  coord_walk_checker #(.W(W), .X_MAX(XM), .Y_MAX(YM), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .locked(locked), .exp_x(exp_x), .exp_y(exp_y), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked; int ex; int ey; bit ep; int ec; bit fd; int fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit m_locked, m_ep, m_fd;
  int m_ex, m_ey, m_ec, m_fc;

  task automatic check_val(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic next_pair(input int x, input int y, output int nx, output int ny);
    if (x < XM)      begin nx = x + 1; ny = y;     end
    else if (y < YM) begin nx = 0;     ny = y + 1; end
    else             begin nx = 0;     ny = 0;     end
  endtask

  task automatic model_step(input bit rst, input bit v, input int x, input int y);
    int nx, ny;
    if (rst) begin
      m_locked = 0; m_ex = 0; m_ey = 0; m_ep = 0; m_ec = 0; m_fd = 0; m_fc = 0;
      return;
    end
    m_ep = 0; m_fd = 0;
    if (!v) return;
    next_pair(x, y, nx, ny);
    if (!m_locked) begin
      if (x == 0 && y == 0) begin m_locked = 1; m_ex = nx; m_ey = ny; end
    end else if (x == m_ex && y == m_ey) begin
      m_ex = nx; m_ey = ny;
      if (x == XM && y == YM) begin m_fd = 1; m_fc = (m_fc + 1) % (1 << CW); end
    end else begin
      m_ep = 1;
      if (m_ec < (1 << CW) - 1) m_ec++;
`ifdef COORD_CHK_RESYNC_EN
      if (x <= XM && y <= YM) begin m_ex = nx; m_ey = ny; end
      else begin m_locked = 0; m_ex = 0; m_ey = 0; end
`else
      m_locked = 0; m_ex = 0; m_ey = 0;
`endif
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input int x, input int y);
    exp_t e;
    reset = rst; in_valid = v; in_x = W'(x); in_y = W'(y);
    model_step(rst, v, x, y);
    e = '{m_locked, m_ex, m_ey, m_ep, m_ec, m_fd, m_fc};
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    check_val("locked",     int'(locked),     int'(e.locked));
    check_val("exp_x",      int'(exp_x),      e.ex);
    check_val("exp_y",      int'(exp_y),      e.ey);
    check_val("err_pulse",  int'(err_pulse),  int'(e.ep));
    check_val("err_cnt",    int'(err_cnt),    e.ec);
    check_val("frame_done", int'(frame_done), int'(e.fd));
    check_val("frame_cnt",  int'(frame_cnt),  e.fc);
    if (err_pulse && frame_done) check_val("pulse_excl", 1, 0);
    $display("[TB] t=%0t rst=%0b v=%0b in=(%0d,%0d) locked=%0b exp=(%0d,%0d) ep=%0b ec=%0d fd=%0b fc=%0d",
             $time, rst, v, x, y, locked, exp_x, exp_y, err_pulse, err_cnt, frame_done, frame_cnt);
  endtask

  task automatic send(input int x, input int y);
    cycle(1'b0, 1'b1, x, y);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 0);
  endtask

  task automatic frame(input bit gaps);
    for (int y = 0; y <= YM; y++)
      for (int x = 0; x <= XM; x++) begin
        send(x, y);
        if (gaps) idle();
      end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b1, 2, 2);

    // Contiguous frame
    send(0, 0);
    check_val("lock_after_00", int'(locked), 1);
    for (int i = 1; i < 16; i++) send(i % 4, i / 4);
    check_val("frame1_cnt", int'(frame_cnt), 1);
    check_val("frame1_err", int'(err_cnt), 0);

    // Lead-in garbage while hunting
    cycle(1'b1, 1'b0, 0, 0);
    send(2, 1); send(3, 1);
    check_val("leadin_locked", int'(locked), 0);
    check_val("leadin_err", int'(err_cnt), 0);
    send(0, 0);
    check_val("leadin_lock", int'(locked), 1);

    // Mismatch at exp=(2,0)
    send(1, 0);
    check_val("pre_err_exp_x", int'(exp_x), 2);
    send(3, 0);
    check_val("mis_err_cnt", int'(err_cnt), 1);
    check_val("mis_pulse", int'(err_pulse), 1);
`ifdef COORD_CHK_RESYNC_EN
    check_val("resync_locked", int'(locked), 1);
    check_val("resync_exp_y", int'(exp_y), 1);
`else
    check_val("mis_locked", int'(locked), 0);
`endif
    idle();
    send(0, 0);

    // Gapped frame must match contiguous results
    cycle(1'b1, 1'b0, 0, 0);
    frame(1'b1);
    check_val("gap_frame_cnt", int'(frame_cnt), 1);
    check_val("gap_err_cnt", int'(err_cnt), 0);

    // Error counter saturation
    cycle(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 300; i++) begin send(0, 0); send(0, 0); end
    check_val("sat_err_cnt", int'(err_cnt), 255);

    // Reset mid-frame at exp=(1,2), with a valid pair in flight
    cycle(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 9; i++) send(i % 4, i / 4);
    check_val("mid_exp_x", int'(exp_x), 1);
    check_val("mid_exp_y", int'(exp_y), 2);
    cycle(1'b1, 1'b1, 1, 2);
    check_val("mid_rst_locked", int'(locked), 0);
    frame(1'b0);
    check_val("post_rst_frame_cnt", int'(frame_cnt), 1);

    // Mostly-correct random walk with occasional corruption and idles
    for (int i = 0; i < 300; i++) begin
      int r, x, y;
      r = int'($urandom_range(0, 9));
      x = m_locked ? m_ex : 0;
      y = m_locked ? m_ey : 0;
      if (r == 0)      idle();
      else if (r == 1) send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      else             send(x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
